// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: host byte stream into the boot loader, valid/ready handshake
interface imem_boot_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    modport master (output in_data, in_valid, input in_ready);
    modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed big-endian image into instruction memory, verifies XOR checksum, then releases the core
module imem_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    input  logic [31:0]         fetch_addr,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_we,
    output logic [31:0]         imem_wdata,
    output logic                core_stall,
    output logic                done,
    output logic                err
);
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CHECK, RUN, ERR} state_t;
    state_t state, nxt;
    logic [7:0] cnt_hi, chk;
    logic [15:0] nwords;
    logic [16:0] wcnt, hdr_n;
    logic [1:0] bcnt;
    logic [23:0] word;
    logic [ADDR_W-1:0] load_addr;
    logic acc, idle_like, last_word, unused;
    assign acc       = bus.in_valid && bus.in_ready;
    assign idle_like = state inside {IDLE, RUN, ERR};
    assign hdr_n     = {1'b0, cnt_hi, bus.in_data};
    assign last_word = bcnt == 2'd3 && wcnt + 17'd1 == {1'b0, nwords};
    assign imem_addr = core_stall ? load_addr : fetch_addr[ADDR_W-1:0];
    assign unused    = ^fetch_addr;
    always_comb begin
        nxt = state;
        case (state)
            IDLE, RUN, ERR: nxt = start ? HDR_HI : state;
            HDR_HI:         nxt = acc ? HDR_LO : state;
            HDR_LO:         nxt = !acc ? state : (hdr_n == 17'd0 || hdr_n > 17'(DEPTH)) ? ERR : DATA;
            DATA:           nxt = acc && last_word ? CHECK : state;
            CHECK:          nxt = !acc ? state : bus.in_data == chk ? RUN : ERR;
            default:        nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            core_stall   <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            imem_we      <= 1'b0;
            imem_wdata   <= '0;
            load_addr    <= '0;
            cnt_hi       <= '0;
            nwords       <= '0;
            wcnt         <= '0;
            bcnt         <= '0;
            chk          <= '0;
            word         <= '0;
        end else begin
            state        <= nxt;
            bus.in_ready <= nxt inside {HDR_HI, HDR_LO, DATA, CHECK};
            core_stall   <= nxt != RUN;
            done         <= nxt == RUN;
            err          <= nxt == ERR;
            imem_we      <= 1'b0;
            if (imem_we) load_addr <= load_addr + 1'b1;
            if (start && idle_like) begin
                wcnt      <= '0;
                bcnt      <= '0;
                chk       <= '0;
                load_addr <= '0;
            end
            if (acc) begin
                case (state)
                    HDR_HI: cnt_hi <= bus.in_data;
                    HDR_LO: nwords <= {cnt_hi, bus.in_data};
                    DATA: begin
                        word <= {word[15:0], bus.in_data};
                        chk  <= chk ^ bus.in_data;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {word, bus.in_data};
                            wcnt       <= wcnt + 17'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed checks of framing, checksum, header bounds, reset and reload
module tb_imem_boot_loader;
    logic clk = 0, rst_n = 1, start = 0;
    logic [31:0] fetch_addr = 32'h3ff;
    logic [9:0] imem_addr, last_addr = 0;
    logic imem_we, core_stall, done, err;
    logic [31:0] imem_wdata;
    logic [31:0] img [0:1023];
    logic [31:0] mem [0:1023];
    int checks = 0, errors = 0, wr_cnt = 0, wr0, bad;
    imem_boot_loader_if bus();
    imem_boot_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .fetch_addr(fetch_addr),
        .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
        .core_stall(core_stall), .done(done), .err(err));
    always #5 clk = ~clk;
    always @(negedge clk) if (imem_we) begin
        mem[imem_addr] <= imem_wdata;
        wr_cnt <= wr_cnt + 1;
        last_addr <= imem_addr;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask
    task automatic send(input logic [7:0] b, input int maxgap);
        bit acc = 0;
        bus.in_data = b;
        bus.in_valid = 1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        check("accept", acc, 1);
        repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    endtask
    task automatic load_img(input int n, input logic [7:0] corrupt, input int maxgap, input bit mid_start);
        logic [7:0] c, b;
        c = 0;
        send(8'(n >> 8), 0);
        send(8'(n), 0);
        for (int w = 0; w < n; w++)
            for (int k = 0; k < 4; k++) begin
                b = img[w][31-8*k -: 8];
                c ^= b;
                send(b, maxgap);
                if (mid_start && w == 0 && k == 1) pulse_start();
            end
        send(c ^ corrupt, 0);
    endtask
    initial begin
        bus.in_data = 0;
        bus.in_valid = 0;
        #2 rst_n = 0;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_stall", core_stall, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", imem_addr, 0);
        #10 rst_n = 1;
        @(posedge clk); #1;
        check("idle_in_ready", bus.in_ready, 0);
        // two-word load with the write strobe checked one cycle after each 4th byte
        pulse_start();
        check("start_in_ready", bus.in_ready, 1);
        send(8'h00, 0); send(8'h02, 0);
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
        check("w0_we", imem_we, 1);
        check("w0_addr", imem_addr, 0);
        check("w0_data", imem_wdata, 32'h12345678);
        send(8'h9a, 0);
        check("w0_we_drop", imem_we, 0);
        send(8'hbc, 0); send(8'hde, 0); send(8'hf0, 0);
        check("w1_we", imem_we, 1);
        check("w1_addr", imem_addr, 1);
        check("w1_data", imem_wdata, 32'h9abcdef0);
        check("pre_chk_done", done, 0);
        send(8'h00, 0);
        check("run_done", done, 1);
        check("run_stall", core_stall, 0);
        check("run_in_ready", bus.in_ready, 0);
        fetch_addr = 32'h405;
        #1 check("fetch_mux", imem_addr, 10'h005);
        check("mem0", mem[0], 32'h12345678);
        check("mem1", mem[1], 32'h9abcdef0);
        // bad checksum then recovery
        img[0] = 32'h12345678;
        img[1] = 32'h9abcdef0;
        pulse_start();
        check("restart_stall", core_stall, 1);
        load_img(2, 8'h89, 0, 0);
        check("badchk_err", err, 1);
        check("badchk_stall", core_stall, 1);
        check("badchk_done", done, 0);
        pulse_start();
        check("recover_err", err, 0);
        load_img(2, 8'h00, 0, 0);
        check("recover_done", done, 1);
        // header bounds
        pulse_start();
        send(8'h00, 0); send(8'h00, 0);
        check("n0_err", err, 1);
        pulse_start();
        send(8'h04, 0); send(8'h01, 0);
        check("n1025_err", err, 1);
        check("n1025_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        wr0 = wr_cnt;
        pulse_start();
        load_img(1024, 8'h00, 0, 0);
        check("n1024_done", done, 1);
        check("n1024_writes", wr_cnt - wr0, 1024);
        check("n1024_last", last_addr, 1023);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== img[i]) bad++;
        check("n1024_image", bad, 0);
        // handshake gaps plus an ignored mid-frame start
        img[0] = 32'hdeadbeef;
        img[1] = 32'h01020304;
        img[2] = 32'hcafef00d;
        pulse_start();
        load_img(3, 8'h00, 3, 1);
        check("gap_done", done, 1);
        check("gap_mem0", mem[0], 32'hdeadbeef);
        check("gap_mem1", mem[1], 32'h01020304);
        check("gap_mem2", mem[2], 32'hcafef00d);
        wr0 = wr_cnt;
        bus.in_valid = 1;
        repeat (3) begin @(posedge clk); #1; end
        bus.in_valid = 0;
        check("run_valid_nowrite", wr_cnt, wr0);
        check("run_valid_done", done, 1);
        // reload from RUN
        fetch_addr = 32'h123;
        #1 check("run_fetch", imem_addr, 10'h123);
        pulse_start();
        check("reload_stall", core_stall, 1);
        check("reload_addr", imem_addr, 0);
        check("reload_done", done, 0);
        img[0] = 32'h55aa55aa;
        load_img(1, 8'h00, 0, 0);
        check("reload_done2", done, 1);
        check("reload_mem0", mem[0], 32'h55aa55aa);
        // async reset mid-DATA with a write strobe pending
        pulse_start();
        send(8'h00, 0); send(8'h02, 0);
        wr0 = wr_cnt;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        check("pre_rst_we", imem_we, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_stall", core_stall, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_addr", imem_addr, 0);
        #3 rst_n = 1;
        bus.in_valid = 1;
        repeat (3) begin @(posedge clk); #1; end
        bus.in_valid = 0;
        check("post_rst_in_ready", bus.in_ready, 0);
        check("post_rst_nowrite", wr_cnt, wr0);
        check("post_rst_mem0", mem[0], 32'h55aa55aa);
        pulse_start();
        check("post_rst_start", bus.in_ready, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
